data_mem_responder: RTL and testbench

Responder end of the load/store control interface: consumes the `MemRead`/`MemWrite` strobes that the main decoder raises for load (`0000011`) and store (`0100011`) opcodes, and serves them from a word-organised data RAM with a configurable access latency. It sits between the datapath's address/store-data outputs and the write-back mux (`MemtoReg` path). It exposes a `busy`/`ready` handshake so a stall-capable core can wait out the latency.

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder serving a word-organised data RAM after a fixed latency
//
// Purpose : accepts MemRead/MemWrite strobes from the core, waits LATENCY
//           cycles, then performs the RAM access and pulses ready. A busy
//           flag covers the whole transaction; strobes seen while busy are
//           dropped.
// Ports   : clk        - single clock, rising edge
//           rst_n      - synchronous active-low reset
//           mem_read   - load strobe (sampled only while busy=0)
//           mem_write  - store strobe (sampled only while busy=0, wins over mem_read)
//           addr       - byte address; word index is addr[log2(DEPTH_WORDS)+1:2]
//           wdata      - store data
//           rdata      - registered load data, held until the next completed load
//           ready      - one-cycle completion pulse
//           busy       - request in flight
//           err        - misaligned access flag, valid with ready
// Options : define DMEM_ALIGN_CHECK_EN to suppress misaligned accesses and
//           report them on err; otherwise err is tied low and addr[1:0] is ignored.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateType;

    stateType         state;
    logic [3:0]       cnt;
    logic             opWrite;
    logic [IDX_W-1:0] idxLatched;
    logic [31:0]      wdataLatched;
    logic [31:0]      ram [DEPTH_WORDS];

    // The access happens on the edge that leaves WAIT for RESP.
    logic accessNow;
    assign accessNow = (state == WAIT) && (cnt == 4'd0);

    // Upper address bits only select an alias of the same word, so they are
    // dropped on purpose; the byte-lane bits matter only with alignment checks.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:IDX_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic misLatched;
    logic accessOk;
    assign accessOk = !misLatched;
`else
    logic accessOk;
    assign accessOk = 1'b1;
    assign err      = 1'b0;
`endif

    // RAM write port. Gated by rst_n so a store caught by reset on its
    // access edge leaves the RAM untouched; contents are never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && accessNow && opWrite && accessOk) begin
            ram[idxLatched] <= wdataLatched;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rdata        <= 32'd0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            opWrite      <= 1'b0;
            idxLatched   <= '0;
            wdataLatched <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            err          <= 1'b0;
            misLatched   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
                    err   <= 1'b0;
`endif
                    if (mem_write || mem_read) begin
                        // Latch everything so the requester may move on.
                        opWrite      <= mem_write;
                        idxLatched   <= addr[IDX_W+1:2];
                        wdataLatched <= wdata;
                        cnt          <= CNT_INIT;
                        busy         <= 1'b1;
                        state        <= WAIT;
`ifdef DMEM_ALIGN_CHECK_EN
                        misLatched   <= (addr[1:0] != 2'b00);
`endif
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        if (!opWrite && accessOk) begin
                            rdata <= ram[idxLatched];
                        end
`ifdef DMEM_ALIGN_CHECK_EN
                        err   <= misLatched;
`endif
                    end
                end
                RESP: begin
                    // Strobes seen here are dropped; the requester re-presents
                    // them in IDLE.
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
                    err   <= 1'b0;
`endif
                end
                default: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr      = 32'd0;
    logic [31:0] wdata     = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: each accepted request is a timestamp; outputs
    // follow from the edge count relative to it.
    logic [31:0] mdlMem [int];
    int          edgeNo   = 0;
    int          accEdge  = 0;
    bit          pending  = 0;
    bit          pWrite   = 0;
    bit          pMis     = 0;
    int          pIdx     = 0;
    logic [31:0] pData    = 32'd0;
    logic [31:0] expRdata = 32'd0;
    bit          rdKnown  = 1;
    bit          expBusy  = 0;
    bit          expReady = 0;
    bit          expErr   = 0;

    always @(posedge clk) begin
        edgeNo++;
        if (!rst_n) begin
            pending  = 0;
            expRdata = 32'd0;
            rdKnown  = 1;
            expBusy  = 0;
            expReady = 0;
            expErr   = 0;
        end else if (pending) begin
            if (edgeNo == accEdge + LAT) begin
                expReady = 1;
                expErr   = pMis;
                if (!pMis) begin
                    if (pWrite) mdlMem[pIdx] = pData;
                    else if (mdlMem.exists(pIdx)) begin
                        expRdata = mdlMem[pIdx];
                        rdKnown  = 1;
                    end else rdKnown = 0;
                end
            end else if (edgeNo == accEdge + LAT + 1) begin
                pending  = 0;
                expBusy  = 0;
                expReady = 0;
                expErr   = 0;
            end
        end else if (mem_write || mem_read) begin
            pending = 1;
            accEdge = edgeNo;
            pWrite  = mem_write;
            pIdx    = int'((addr >> 2) % DEPTH);
            pData   = wdata;
`ifdef DMEM_ALIGN_CHECK_EN
            pMis    = (addr[1:0] != 2'b00);
`else
            pMis    = 0;
`endif
            expBusy = 1;
        end
    end

    bit cmpOn = 0;
    always @(negedge clk) begin
        if (cmpOn) begin
            chk("busy", busy, expBusy);
            chk("ready", ready, expReady);
            chk("err", err, expErr);
            if (rdKnown) chk("rdata", rdata, expRdata);
        end
    end

    task automatic doReq(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = w;
        mem_read  = r;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        mem_write = 0;
        mem_read  = 0;
        addr      = $urandom;
        wdata     = $urandom;
    endtask

    task automatic waitReady(input string name, output logic [31:0] rd, output logic er);
        int i = 0;
        while (!ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_ready_seen"}, ready, 1);
        rd = rdata;
        er = err;
        @(negedge clk);
    endtask

    task automatic access(input string name, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        doReq(w, !w, a, d);
        waitReady(name, rd, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [3:0]  bh;
        logic [3:0]  rh;
        int          pulses;

        rst_n = 0;
        repeat (3) @(negedge clk);
        cmpOn = 1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        chk("reset_err", err, 0);
        rst_n = 1;

        // Give every word used below a known value.
        access("pre20", 1, 32'h20, 32'h11111111, rd, er);
        access("pre08", 1, 32'h08, 32'h22222222, rd, er);
        access("pre04", 1, 32'h04, 32'h33333333, rd, er);
        access("pre00", 1, 32'h00, 32'h44444444, rd, er);
        access("pre10", 1, 32'h10, 32'h66666666, rd, er);
        access("pre0c", 1, 32'h0C, 32'h0C0C0C0C, rd, er);

        // Store with exact busy/ready timing.
        @(negedge clk);
        mem_write = 1;
        addr      = 32'h10;
        wdata     = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                mem_write = 0;
                addr      = 32'h0;
                wdata     = 32'h0;
            end
            bh[3-i] = busy;
            rh[3-i] = ready;
        end
        chk("store_busy_window", bh, 4'b1110);
        chk("store_ready_pulse", rh, 4'b0010);
        access("load10", 0, 32'h10, 32'h0, rd, er);
        chk("load10_data", rd, 32'hDEADBEEF);

        // Read strobe during a store's WAIT is dropped.
        doReq(1, 0, 32'h0C, 32'hC0C0C0C0);
        mem_read = 1;
        addr     = 32'h20;
        @(negedge clk);
        mem_read = 0;
        waitReady("st0c", rd, er);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        chk("dropped_no_ready", pulses, 0);
        access("load20", 0, 32'h20, 32'h0, rd, er);
        chk("load20_data", rd, 32'h11111111);

        // Both strobes high: store wins, rdata untouched.
        doReq(1, 1, 32'h04, 32'h12345678);
        waitReady("both", rd, er);
        chk("both_rdata_kept", rd, 32'h11111111);
        access("load04", 0, 32'h04, 32'h0, rd, er);
        chk("load04_data", rd, 32'h12345678);

        // Wrap-around modulo DEPTH*4 bytes.
        access("st400", 1, 32'h400, 32'hA5A5A5A5, rd, er);
        access("load00", 0, 32'h000, 32'h0, rd, er);
        chk("wrap_data", rd, 32'hA5A5A5A5);

        // Reset during WAIT of a store abandons it.
        doReq(1, 0, 32'h08, 32'h00000055);
        rst_n = 0;
        @(negedge clk);
        chk("rst_wait_rdata", rdata, 32'd0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_ready", ready, 0);
        chk("rst_wait_err", err, 0);
        rst_n = 1;
        access("load08", 0, 32'h08, 32'h0, rd, er);
        chk("load08_data", rd, 32'h22222222);

        // Held read strobe: re-accepted every LAT+2 cycles.
        @(negedge clk);
        mem_read = 1;
        addr     = 32'h04;
        pulses   = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        mem_read = 0;
        chk("held_ready_count", pulses, 3);
        repeat (6) @(negedge clk);

        // Misaligned store.
        access("st13", 1, 32'h13, 32'h99999999, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("st13_err", er, 1);
        access("load10b", 0, 32'h10, 32'h0, rd, er);
        chk("load10b_data", rd, 32'hDEADBEEF);
        access("load11", 0, 32'h11, 32'h0, rd, er);
        chk("load11_err", er, 1);
        chk("load11_rdata_kept", rd, 32'hDEADBEEF);
`else
        chk("st13_err", er, 0);
        access("load10b", 0, 32'h10, 32'h0, rd, er);
        chk("load10b_data", rd, 32'h99999999);
        chk("load10b_err", er, 0);
`endif

        repeat (3) @(negedge clk);
        cmpOn = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
